// File: rtl/uart_tx_module_if.sv
// ----------------------------------------------------------------------------
// uart_tx_module_if
//   Handshake and line signals between a UART transmitter and its user.
//
//   tick      baud enable, one clk wide, 16x (OVERSAMPLE x) the bit rate
//   tx_start  request to send tx_data (taken only when the transmitter idles)
//   tx_data   word to send, bit 0 goes out first
//   n_bits    number of data bits (clamped to 5..8 by the transmitter)
//   tx        serial line, idles high
//   busy      frame in progress
//   done      one-cycle pulse at the end of the stop bit
//
//   master : the user side (drives tick/tx_start/tx_data/n_bits)
//   slave  : the transmitter side (drives tx/busy/done)
// ----------------------------------------------------------------------------
interface uart_tx_module_if;
  logic       tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] n_bits;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output tick,
    output tx_start,
    output tx_data,
    output n_bits,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  tick,
    input  tx_start,
    input  tx_data,
    input  n_bits,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx_module.sv
// ----------------------------------------------------------------------------
// uart_tx_module
//   UART serial transmitter: 1 start bit (low), 5..8 data bits LSB first,
//   1 stop bit (high). Bit timing is taken from the shared tick enable that
//   runs at OVERSAMPLE x the baud rate, so every bit lasts OVERSAMPLE ticks.
//
//   Parameters
//     OVERSAMPLE  tick pulses per bit; power of two in 2..16
//
//   Ports
//     clk   system clock, rising edge
//     rst   synchronous, active-high reset
//     bus   uart_tx_module_if.slave (tick, tx_start, tx_data, n_bits in;
//           tx, busy, done out). All outputs are registered.
// ----------------------------------------------------------------------------
module uart_tx_module #(
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_module_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  // Out-of-range requests are forced into the 5..8 range the framer supports.
  function automatic logic [3:0] clamp_len(input logic [3:0] n);
    logic [3:0] r;
    if (n < 4'd5)
      r = 4'd5;
    else if (n > 4'd8)
      r = 4'd8;
    else
      r = n;
    return r;
  endfunction

  state_t     state_p0, state_n;
  logic [3:0] tick_cnt_p0, tick_cnt_n;
  logic [2:0] bit_cnt_p0, bit_cnt_n;
  logic [7:0] shift_p0, shift_n;
  logic [3:0] len_p0, len_n;
  logic       tx_p0, tx_n;
  logic       busy_p0, busy_n;
  logic       done_p0, done_n;

  logic       bit_end;
  logic       last_bit;

  assign bit_end  = bus.tick && (tick_cnt_p0 == TICK_LAST);
  // bit_cnt is 3 bits and len reaches 8, so compare in the 4-bit domain.
  assign last_bit = ({1'b0, bit_cnt_p0} == (len_p0 - 4'd1));

  always_comb begin
    state_n    = state_p0;
    tick_cnt_n = tick_cnt_p0;
    bit_cnt_n  = bit_cnt_p0;
    shift_n    = shift_p0;
    len_n      = len_p0;
    done_n     = 1'b0;

    unique case (state_p0)
      IDLE: begin
        // A tick here is deliberately ignored, including one coinciding
        // with tx_start, so the start bit always gets a full count.
        if (bus.tx_start) begin
          shift_n    = bus.tx_data;
          len_n      = clamp_len(bus.n_bits);
          tick_cnt_n = 4'd0;
          state_n    = START;
        end
      end

      START: begin
        if (bus.tick) begin
          if (bit_end) begin
            tick_cnt_n = 4'd0;
            bit_cnt_n  = 3'd0;
            state_n    = DATA;
          end else begin
            tick_cnt_n = tick_cnt_p0 + 4'd1;
          end
        end
      end

      DATA: begin
        if (bus.tick) begin
          if (bit_end) begin
            tick_cnt_n = 4'd0;
            shift_n    = {1'b0, shift_p0[7:1]};
            bit_cnt_n  = bit_cnt_p0 + 3'd1;
            if (last_bit)
              state_n = STOP;
          end else begin
            tick_cnt_n = tick_cnt_p0 + 4'd1;
          end
        end
      end

      STOP: begin
        if (bus.tick) begin
          if (bit_end) begin
            tick_cnt_n = 4'd0;
            state_n    = IDLE;
            done_n     = 1'b1;
          end else begin
            tick_cnt_n = tick_cnt_p0 + 4'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registered line
    // changes exactly one cycle after the deciding edge and never mid-bit.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Stage p0: control state and registered outputs (reset applies here)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= IDLE;
      tick_cnt_p0 <= 4'd0;
      bit_cnt_p0  <= 3'd0;
      tx_p0       <= 1'b1;
      busy_p0     <= 1'b0;
      done_p0     <= 1'b0;
    end else begin
      state_p0    <= state_n;
      tick_cnt_p0 <= tick_cnt_n;
      bit_cnt_p0  <= bit_cnt_n;
      tx_p0       <= tx_n;
      busy_p0     <= busy_n;
      done_p0     <= done_n;
    end
  end

  // Stage p0: frame data; only consumed once a frame has been accepted
  always_ff @(posedge clk) begin
    shift_p0 <= shift_n;
    len_p0   <= len_n;
  end

  assign bus.tx   = tx_p0;
  assign bus.busy = busy_p0;
  assign bus.done = done_p0;

endmodule

// File: tb/tb_uart_tx_module.sv
module tb_uart_tx_module;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  longint cyc;
  int   phase;

  uart_tx_module_if ifc ();

  uart_tx_module #(.OVERSAMPLE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Observed tx value at every tick inside a frame, and the model's version.
  logic cap_q[$];
  logic exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick every 4 clk cycles, free running.
  initial begin
    ifc.tick = 1'b0;
    phase    = 0;
    cyc      = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      phase    = (phase + 1) % 4;
      ifc.tick = (phase == 0);
    end
  end

  // Reference model: frame as a list of line levels, one per tick.
  function automatic int model_len(input int nb);
    if (nb < 5) return 5;
    if (nb > 8) return 8;
    return nb;
  endfunction

  function automatic void build_expected(input logic [7:0] data, input int nb);
    int len;
    len = model_len(nb);
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(1'b0);
    for (int b = 0; b < len; b++)
      for (int k = 0; k < 16; k++) exp_q.push_back(data[b]);
    for (int k = 0; k < 16; k++) exp_q.push_back(1'b1);
  endfunction

  function automatic int count_diff();
    int d;
    d = 0;
    if (cap_q.size() != exp_q.size()) return -1;
    foreach (exp_q[i]) if (cap_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // Records one frame: waits for busy, logs tx at each tick while busy,
  // and reports what the line did when busy fell.
  task automatic capture(output int wait_cyc, output logic first_tx,
                         output logic done_ok, output int glitches,
                         output longint done_at);
    logic prev_tx, prev_tick, fin;
    int   n;
    cap_q.delete();
    wait_cyc = 0; first_tx = 1'b1; done_ok = 1'b0; glitches = 0; done_at = 0;
    @(negedge clk);
    while (ifc.busy !== 1'b1 && wait_cyc < 2000) begin
      wait_cyc++;
      @(negedge clk);
    end
    if (ifc.busy === 1'b1) begin
      first_tx  = ifc.tx;
      prev_tx   = ifc.tx;
      prev_tick = ifc.tick;
      if (ifc.tick) cap_q.push_back(ifc.tx);
      fin = 1'b0;
      n   = 0;
      while (!fin && n < 3000) begin
        @(negedge clk);
        n++;
        if (ifc.tx !== prev_tx && !prev_tick) glitches++;
        if (ifc.busy !== 1'b1) begin
          done_ok = (ifc.done === 1'b1) && (ifc.tx === 1'b1);
          done_at = cyc;
          fin     = 1'b1;
        end else begin
          if (ifc.tick) cap_q.push_back(ifc.tx);
          prev_tx   = ifc.tx;
          prev_tick = ifc.tick;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.tx_start = 1'b0;
    ifc.tx_data  = 8'h00;
    ifc.n_bits   = 4'd8;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", ifc.tx); end
    checks++;
    if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", ifc.busy); end
    checks++;
    if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", ifc.done); end
    // Ticks while idle must not start anything.
    repeat (20) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b0 || ifc.tx !== 1'b1) begin
      errors++; $display("FAIL idle_tick busy=%b tx=%b want busy=0 tx=1", ifc.busy, ifc.tx);
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] data, input int nb);
    int wc, gl, d; logic ft, dok; longint da;
    @(posedge clk); #1;
    ifc.tx_data = data; ifc.n_bits = 4'(nb); ifc.tx_start = 1'b1;
    @(posedge clk); #1;
    ifc.tx_start = 1'b0;
    // Scribble over the inputs: the frame must already be latched.
    ifc.tx_data = 8'($urandom); ifc.n_bits = 4'($urandom);
    build_expected(data, nb);
    capture(wc, ft, dok, gl, da);
    checks++;
    if (wc != 0 || ft !== 1'b0) begin
      errors++; $display("FAIL %s accept wait=%0d tx=%b want wait=0 tx=0", name, wc, ft);
    end
    d = count_diff();
    checks++;
    if (d != 0) begin
      errors++; $display("FAIL %s bits ticks=%0d diffs=%0d want ticks=%0d diffs=0", name, cap_q.size(), d, exp_q.size());
    end
    checks++;
    if (!dok || gl != 0) begin
      errors++; $display("FAIL %s end done_ok=%b glitches=%0d want 1/0", name, dok, gl);
    end
    @(negedge clk);
    checks++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++; $display("FAIL %s after done=%b busy=%b want 0/0", name, ifc.done, ifc.busy);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] data; int nb;
    for (int i = 0; i < 6; i++) begin
      data = 8'($urandom);
      nb   = int'($urandom_range(0, 15));
      test_frame($sformatf("rand%0d", i), data, nb);
    end
  endtask

  task automatic test_ignored_start();
    int wc, gl, d, busy_seen; logic ft, dok; longint da;
    @(posedge clk); #1;
    ifc.tx_data = 8'hFF; ifc.n_bits = 4'd8; ifc.tx_start = 1'b1;
    @(posedge clk); #1;
    ifc.tx_start = 1'b0;
    build_expected(8'hFF, 8);
    fork
      capture(wc, ft, dok, gl, da);
      begin
        repeat (300) @(posedge clk);
        #1 ifc.tx_data = 8'h00; ifc.tx_start = 1'b1;
        @(posedge clk);
        #1 ifc.tx_start = 1'b0;
      end
    join
    d = count_diff();
    checks++;
    if (d != 0) begin
      errors++; $display("FAIL ignored_bits ticks=%0d diffs=%0d want ticks=%0d diffs=0", cap_q.size(), d, exp_q.size());
    end
    checks++;
    if (!dok) begin errors++; $display("FAIL ignored_done got=%b want=1", dok); end
    busy_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++; $display("FAIL ignored_second active_cycles=%0d want=0", busy_seen);
    end
  endtask

  task automatic test_back_to_back();
    int wc1, wc2, gl1, gl2, d, extra; logic ft1, ft2, dok1, dok2; longint da1, da2;
    @(posedge clk); #1;
    ifc.tx_data = 8'h55; ifc.n_bits = 4'd8; ifc.tx_start = 1'b1;
    @(posedge clk); #1;
    ifc.tx_data = 8'h0F;
    build_expected(8'h55, 8);
    capture(wc1, ft1, dok1, gl1, da1);
    d = count_diff();
    checks++;
    if (d != 0 || !dok1) begin
      errors++; $display("FAIL b2b_frame1 diffs=%0d done_ok=%b want 0/1", d, dok1);
    end
    fork
      capture(wc2, ft2, dok2, gl2, da2);
      begin
        @(posedge clk);
        #1 ifc.tx_start = 1'b0;
      end
    join
    build_expected(8'h0F, 8);
    d = count_diff();
    checks++;
    if (d != 0 || !dok2) begin
      errors++; $display("FAIL b2b_frame2 diffs=%0d done_ok=%b want 0/1", d, dok2);
    end
    checks++;
    if (wc2 != 0 || ft2 !== 1'b0) begin
      errors++; $display("FAIL b2b_gap wait=%0d tx=%b want 0/0", wc2, ft2);
    end
    checks++;
    if (da2 - da1 != 640) begin
      errors++; $display("FAIL b2b_spacing got=%0d want=640 cycles", da2 - da1);
    end
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL b2b_third busy_cycles=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(posedge clk); #1;
    ifc.tx_data = 8'h00; ifc.n_bits = 4'd8; ifc.tx_start = 1'b1;
    @(posedge clk); #1;
    ifc.tx_start = 1'b0;
    repeat (288) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b1 || ifc.tx !== 1'b0) begin
      errors++; $display("FAIL rstmid_pre busy=%b tx=%b want 1/0", ifc.busy, ifc.tx);
    end
    // Reset together with a start request: reset must win.
    @(posedge clk); #1;
    rst = 1'b1; ifc.tx_start = 1'b1; ifc.tx_data = 8'hAA;
    @(posedge clk); #1;
    rst = 1'b0; ifc.tx_start = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.tx !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      errors++; $display("FAIL rstmid_post tx=%b busy=%b done=%b want 1/0/0", ifc.tx, ifc.busy, ifc.done);
    end
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rstmid_quiet active_cycles=%0d want=0", seen); end
    test_frame("after_rst", 8'h3C, 8);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_frame("f8_A5", 8'hA5, 8);
    test_frame("f5_F3", 8'hF3, 5);
    test_frame("clamp_lo", 8'h6B, 2);
    test_frame("clamp_hi", 8'h81, 12);
    test_random_frames();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
